// File: rtl/sram_like_pkg.sv
// Shared types for the sram-like port arbiter: FSM state codes, transfer
// sizes, and a bundled view of one master's request fields.
package sram_like_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    D_REQ  = 3'd2,
    I_DATA = 3'd3,
    D_DATA = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  function automatic logic owner_is_inst(input state_t s);
    return (s == I_REQ) || (s == I_DATA);
  endfunction

  function automatic logic owner_is_data(input state_t s);
    return (s == D_REQ) || (s == D_DATA);
  endfunction

endpackage

// File: rtl/sram_like_arbiter.sv
// Two-to-one arbiter sharing one sram-like memory port between the inst and
// data converters; one outstanding transaction, data first, bounded inst wait.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok1,
  output logic        inst_data_ok2,
  output logic [31:0] inst_rdata1,
  output logic [31:0] inst_rdata2,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok1,
  input  logic        mem_data_ok2,
  input  logic [31:0] mem_rdata1,
  input  logic [31:0] mem_rdata2,
  output logic        busy,
  output state_t      state,
  output logic [2:0]  starve_cnt
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  // Handshake: a request is accepted in the cycle where mem_req and
  // mem_addr_ok are both high; the response is the first mem_data_ok1 at or
  // after that cycle. Only the owning master ever sees addr_ok or data_ok.
  sram_req_t inst_bus;
  sram_req_t data_bus;
  sram_req_t sel;
  logic      own_i;
  logic      own_d;
  logic      req_phase;

  always_comb begin
    inst_bus = '{req: inst_req, wr: inst_wr, size: inst_size,
                 addr: inst_addr, wdata: inst_wdata};
    data_bus = '{req: data_req, wr: data_wr, size: data_size,
                 addr: data_addr, wdata: data_wdata};
  end

  assign own_i     = owner_is_inst(state);
  assign own_d     = owner_is_data(state);
  assign req_phase = (state == I_REQ) || (state == D_REQ);

  always_comb begin
    sel = '0;
    if (own_i) begin
      sel = inst_bus;
    end else if (own_d) begin
      sel = data_bus;
    end
  end

  // Fields stay with the owner through the data phase; only req drops.
  assign mem_req   = sel.req & req_phase;
  assign mem_wr    = sel.wr;
  assign mem_size  = sel.size;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;

  assign inst_addr_ok  = (state == I_REQ) & mem_addr_ok;
  assign data_addr_ok  = (state == D_REQ) & mem_addr_ok;
  assign inst_data_ok1 = own_i & mem_data_ok1;
  assign inst_data_ok2 = own_i & mem_data_ok2;
  assign data_data_ok  = own_d & mem_data_ok1;

  assign inst_rdata1 = mem_rdata1;
  assign inst_rdata2 = mem_rdata2;
  assign data_rdata  = mem_rdata1;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_req && (starve_cnt == LIMIT)) begin
            state      <= I_REQ;
            starve_cnt <= 3'd0;
          end else if (data_req) begin
            state <= D_REQ;
            if (!inst_req) begin
              starve_cnt <= 3'd0;
            end else if (starve_cnt < LIMIT) begin
              starve_cnt <= starve_cnt + 3'd1;
            end
          end else if (inst_req) begin
            state      <= I_REQ;
            starve_cnt <= 3'd0;
          end else begin
            starve_cnt <= 3'd0;
          end
        end
        I_REQ, D_REQ: begin
          // A withdrawn request abandons the slot without any handshake.
          if (!sel.req) begin
            state <= IDLE;
          end else if (mem_addr_ok && mem_data_ok1) begin
            state <= IDLE;
          end else if (mem_addr_ok) begin
            state <= (state == I_REQ) ? I_DATA : D_DATA;
          end
        end
        I_DATA, D_DATA: begin
          if (mem_data_ok1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: expected grants and responses are
// queued as stimulus is issued and a monitor pops them as the DUT emits them.
module tb_sram_like_arbiter;
  import sram_like_pkg::*;

  localparam int W = 70;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok1, inst_data_ok2;
  logic [31:0] inst_rdata1, inst_rdata2;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok1, mem_data_ok2;
  logic [31:0] mem_rdata1, mem_rdata2;
  logic        busy;
  state_t      state;
  logic [2:0]  starve_cnt;

  logic        aok_en;
  logic        comb_mode;
  logic        dpulse;
  logic [31:0] rd1, rd2;
  int          pend;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int mreq_cnt = 0, busy_cnt = 0, iok_cnt = 0, dok_cnt = 0, stray_cnt = 0;

  sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok1(inst_data_ok1),
    .inst_data_ok2(inst_data_ok2), .inst_rdata1(inst_rdata1),
    .inst_rdata2(inst_rdata2),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok1(mem_data_ok1),
    .mem_data_ok2(mem_data_ok2), .mem_rdata1(mem_rdata1),
    .mem_rdata2(mem_rdata2),
    .busy(busy), .state(state), .starve_cnt(starve_cnt)
  );

  // Clock and watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Slave: addr_ok with mem_req; data_ok1/ok2 either in the same cycle
  // (comb_mode) or two cycles after the accepting cycle.
  assign mem_addr_ok  = mem_req & aok_en;
  assign mem_data_ok1 = dpulse | (mem_addr_ok & comb_mode);
  assign mem_data_ok2 = mem_data_ok1;
  assign mem_rdata1   = rd1;
  assign mem_rdata2   = rd2;

  initial begin
    dpulse = 1'b0;
    pend   = 0;
    forever begin
      @(posedge clk);
      #2;
      dpulse = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) dpulse = 1'b1;
      end
      if (mem_req && mem_addr_ok && !comb_mode) pend = 2;
    end
  end

  function automatic logic [W-1:0] ev_grant(input logic [2:0] tag, input logic wr,
                                            input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    return {tag, wr, size, addr, wdata};
  endfunction

  function automatic logic [W-1:0] ev_irsp(input logic [31:0] r1, input logic [31:0] r2);
    return {3'd3, 3'b011, r1, r2};
  endfunction

  function automatic logic [W-1:0] ev_drsp(input logic [31:0] r);
    return {3'd4, 3'b001, r, 32'h0};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event %h with empty queue", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  task automatic monitor();
    logic [2:0] tg;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (mem_req) mreq_cnt++;
        if (busy) busy_cnt++;
        if (inst_data_ok1) iok_cnt++;
        if (data_data_ok) dok_cnt++;
        if (state == IDLE && mem_data_ok1) stray_cnt++;
        if ((inst_addr_ok || data_addr_ok) && !(mem_req && mem_addr_ok))
          check("spurious_addr_ok", W'({inst_addr_ok, data_addr_ok}), W'(0));
        if (mem_req && mem_addr_ok) begin
          tg = (inst_addr_ok && !data_addr_ok) ? 3'd1 :
               (data_addr_ok && !inst_addr_ok) ? 3'd2 : 3'd7;
          sb_check("grant", ev_grant(tg, mem_wr, mem_size, mem_addr, mem_wdata));
        end
        if (inst_data_ok1 || inst_data_ok2)
          sb_check("inst_rsp", {3'd3, 1'b0, inst_data_ok2, inst_data_ok1, inst_rdata1, inst_rdata2});
        if (data_data_ok)
          sb_check("data_rsp", ev_drsp(data_rdata));
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the negedge where the chosen master's addr_ok is seen.
  task automatic wait_ack(input string name, input logic is_inst, input int bound);
    int got;
    got = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (is_inst ? inst_addr_ok : data_addr_ok) begin
        got = 1;
        break;
      end
    end
    check(name, W'(got), W'(1));
  endtask

  task automatic data_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    data_wr = wr; data_addr = addr; data_wdata = wdata; data_size = SIZE_WORD;
    data_req = 1'b1;
    wait_ack("data_ack", 1'b0, 40);
    @(posedge clk); #1;
    data_req = 1'b0; data_wr = 1'b0; data_wdata = 32'h0;
  endtask

  task automatic inst_txn(input logic [31:0] addr);
    inst_addr = addr; inst_size = SIZE_WORD;
    inst_req = 1'b1;
    wait_ack("inst_ack", 1'b1, 40);
    @(posedge clk); #1;
    inst_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, W'(state), W'(IDLE));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_mem_req"}, W'(mem_req), W'(0));
    check({tag, "_addr_ok"}, W'({inst_addr_ok, data_addr_ok}), W'(0));
    check({tag, "_data_ok"}, W'({inst_data_ok1, inst_data_ok2, data_data_ok}), W'(0));
    check({tag, "_mem_fields"}, W'({mem_wr, mem_size, mem_addr, mem_wdata}), W'(0));
  endtask

  initial begin
    int b_mreq, b_busy, b_iok, b_dok, b_stray;
    logic [2:0] sexp [5];
    sexp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    resetn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_WORD;
    inst_addr = 32'hBFC0_0000; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD;
    data_addr = 32'h0; data_wdata = 32'h0;
    aok_en = 1'b1; comb_mode = 1'b0; rd1 = 32'h0; rd2 = 32'h0;
    fork monitor(); join_none

    // Reset values, with a non-zero but unrequested inst address present
    step(3);
    check_idle_outputs("rst");
    check("rst_starve", W'(starve_cnt), W'(0));
    resetn = 1'b1;
    step(2);

    // Inst only: one-cycle arbitration, delayed data_ok1 & ok2
    rd1 = 32'h11; rd2 = 32'h22;
    b_mreq = mreq_cnt; b_iok = iok_cnt; b_dok = dok_cnt;
    exp_q.push_back(ev_grant(3'd1, 1'b0, SIZE_WORD, 32'hBFC0_0000, 32'h0));
    exp_q.push_back(ev_irsp(32'h11, 32'h22));
    inst_addr = 32'hBFC0_0000; inst_req = 1'b1;
    @(negedge clk);
    check("lat_cycle0_mem_req", W'(mem_req), W'(0));
    @(negedge clk);
    check("lat_cycle1_mem_req", W'(mem_req), W'(1));
    check("lat_cycle1_addr", W'(mem_addr), W'(32'hBFC0_0000));
    @(posedge clk); #1;
    inst_req = 1'b0;
    step(5);
    check("t1_mem_req_cycles", W'(mreq_cnt - b_mreq), W'(1));
    check("t1_inst_ok_pulses", W'(iok_cnt - b_iok), W'(1));
    check("t1_data_ok_pulses", W'(dok_cnt - b_dok), W'(0));

    // Simultaneous requests: data wins, inst follows on next IDLE
    rd1 = 32'h33; rd2 = 32'h44;
    exp_q.push_back(ev_grant(3'd2, 1'b1, SIZE_WORD, 32'h0000_2000, 32'hA5A5_A5A5));
    exp_q.push_back(ev_drsp(32'h33));
    exp_q.push_back(ev_grant(3'd1, 1'b0, SIZE_WORD, 32'hBFC0_0004, 32'h0));
    exp_q.push_back(ev_irsp(32'h33, 32'h44));
    fork
      data_txn(1'b1, 32'h0000_2000, 32'hA5A5_A5A5);
      inst_txn(32'hBFC0_0004);
    join
    step(5);

    // Starvation bound: D,D,D,D,I,D with same-cycle addr_ok/data_ok
    comb_mode = 1'b1; rd1 = 32'h55; rd2 = 32'h66;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ev_grant(3'd2, 1'b0, SIZE_WORD, 32'h0000_1000, 32'h0));
      exp_q.push_back(ev_drsp(32'h55));
    end
    exp_q.push_back(ev_grant(3'd1, 1'b0, SIZE_WORD, 32'hBFC0_0008, 32'h0));
    exp_q.push_back(ev_irsp(32'h55, 32'h66));
    exp_q.push_back(ev_grant(3'd2, 1'b0, SIZE_WORD, 32'h0000_1000, 32'h0));
    exp_q.push_back(ev_drsp(32'h55));
    fork
      begin
        data_addr = 32'h0000_1000; data_wr = 1'b0; data_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
          wait_ack($sformatf("starve_ack_d%0d", k), 1'b0, 40);
          check($sformatf("starve_cnt_d%0d", k), W'(starve_cnt), W'(sexp[k]));
        end
        @(posedge clk); #1;
        data_req = 1'b0;
      end
      begin
        inst_addr = 32'hBFC0_0008; inst_req = 1'b1;
        wait_ack("starve_ack_i", 1'b1, 60);
        check("starve_cnt_after_i", W'(starve_cnt), W'(0));
        @(posedge clk); #1;
        inst_req = 1'b0;
      end
    join
    step(4);

    // Same-cycle addr_ok and data_ok1 on a data write
    rd1 = 32'h77;
    b_busy = busy_cnt; b_dok = dok_cnt;
    exp_q.push_back(ev_grant(3'd2, 1'b1, SIZE_WORD, 32'h0000_3000, 32'hDEAD_BEEF));
    exp_q.push_back(ev_drsp(32'h77));
    data_txn(1'b1, 32'h0000_3000, 32'hDEAD_BEEF);
    step(3);
    check("t4_busy_cycles", W'(busy_cnt - b_busy), W'(1));
    check("t4_data_ok_pulses", W'(dok_cnt - b_dok), W'(1));

    // Data withdraws in D_REQ before addr_ok; pending inst then wins
    comb_mode = 1'b0; aok_en = 1'b0; rd1 = 32'h88; rd2 = 32'h99;
    b_iok = iok_cnt; b_dok = dok_cnt;
    exp_q.push_back(ev_grant(3'd1, 1'b0, SIZE_WORD, 32'hBFC0_000C, 32'h0));
    exp_q.push_back(ev_irsp(32'h88, 32'h99));
    data_addr = 32'h0000_4000; data_req = 1'b1;
    inst_addr = 32'hBFC0_000C; inst_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_held_state", W'(state), W'(D_REQ));
    @(posedge clk); #1;
    data_req = 1'b0; aok_en = 1'b1;
    @(negedge clk);
    check("t5_drop_mem_req", W'(mem_req), W'(0));
    wait_ack("t5_inst_ack", 1'b1, 40);
    @(posedge clk); #1;
    inst_req = 1'b0;
    step(5);
    check("t5_inst_ok_pulses", W'(iok_cnt - b_iok), W'(1));
    check("t5_data_ok_pulses", W'(dok_cnt - b_dok), W'(0));

    // Reset in I_DATA; the late data_ok1 must reach nobody
    b_iok = iok_cnt; b_stray = stray_cnt;
    exp_q.push_back(ev_grant(3'd1, 1'b0, SIZE_WORD, 32'hBFC0_0010, 32'h0));
    inst_addr = 32'hBFC0_0010; inst_req = 1'b1;
    wait_ack("t6_inst_ack", 1'b1, 40);
    @(posedge clk); #1;
    inst_req = 1'b0;
    check("t6_in_i_data", W'(state), W'(I_DATA));
    #1 resetn = 1'b0;
    #1 check("t6_async_state", W'(state), W'(IDLE));
    check("t6_async_mem_req", W'(mem_req), W'(0));
    #3 resetn = 1'b1;
    step(3);
    check("t6_inst_ok_pulses", W'(iok_cnt - b_iok), W'(0));
    check("t6_stray_seen", W'(stray_cnt > b_stray), W'(1));
    check_idle_outputs("t6");
    check("t6_starve", W'(starve_cnt), W'(0));

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
